// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM with a shared memory req/ready handshake and wait timeout.
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to trap undecoded instructions into HALT.
module mc_ctrl #(
   parameter int unsigned ALUOP_W  = 4,
   parameter int unsigned WAIT_W   = 4,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               Zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic               IorD,
   output logic               IRWrite,
   output logic               PCWrite,
   output logic [1:0]         NPCOp,
   output logic               RegWrite,
   output logic               MemWrite,
   output logic               ALUSrc,
   output logic               AregSel,
   output logic               EXTOp,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic [1:0]         GPRSel,
   output logic [1:0]         WDSel,
   output logic               instr_done,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   output logic               bus_err,
   output logic               illegal
`else
   output logic               bus_err
`endif
);

   localparam logic [3:0] ALU_NOP  = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_AND  = 4'd3;
   localparam logic [3:0] ALU_OR   = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_NOR  = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd10;
   localparam logic [3:0] ALU_XOR  = 4'd11;
   localparam logic [3:0] ALU_SRA  = 4'd12;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      K_NOP, K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_JALR
   } kind_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [5:0]        op_q, funct_q, dec_op, dec_funct;
   logic              bus_err_d;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic              illegal_d;
`endif

   kind_t      kind;
   logic [3:0] alu_code;
   logic       alu_src, areg_sel, ext_op;
   logic       retire;

   // Decode the live IR during DECODE, the latched copy afterwards.
   assign dec_op    = (state_q == S_DECODE) ? Op    : op_q;
   assign dec_funct = (state_q == S_DECODE) ? Funct : funct_q;

   // Instruction decoder; an undecoded encoding is reported as K_NOP.
   always_comb begin
      kind     = K_NOP;
      alu_code = ALU_NOP;
      alu_src  = 1'b0;
      areg_sel = 1'b0;
      ext_op   = 1'b0;
      case (dec_op)
         6'h00: begin
            kind = K_ALU;
            case (dec_funct)
               6'h20, 6'h21: alu_code = ALU_ADD;
               6'h22, 6'h23: alu_code = ALU_SUB;
               6'h24:        alu_code = ALU_AND;
               6'h25:        alu_code = ALU_OR;
               6'h26:        alu_code = ALU_XOR;
               6'h27:        alu_code = ALU_NOR;
               6'h2a:        alu_code = ALU_SLT;
               6'h2b:        alu_code = ALU_SLTU;
               6'h00:        begin alu_code = ALU_SLL; areg_sel = 1'b1; end
               6'h02:        begin alu_code = ALU_SRL; areg_sel = 1'b1; end
               6'h03:        begin alu_code = ALU_SRA; areg_sel = 1'b1; end
               6'h04:        alu_code = ALU_SLL;
               6'h06:        alu_code = ALU_SRL;
               6'h07:        alu_code = ALU_SRA;
               6'h08:        kind = K_JR;
               6'h09:        kind = K_JALR;
               default:      kind = K_NOP;
            endcase
         end
         6'h02: kind = K_J;
         6'h03: kind = K_JAL;
         6'h04: begin kind = K_BEQ; alu_code = ALU_SUB; ext_op = 1'b1; end
         6'h05: begin kind = K_BNE; alu_code = ALU_SUB; ext_op = 1'b1; end
         6'h08: begin kind = K_ALU; alu_code = ALU_ADD; alu_src = 1'b1; ext_op = 1'b1; end
         6'h0a: begin kind = K_ALU; alu_code = ALU_SLT; alu_src = 1'b1; ext_op = 1'b1; end
         6'h0c: begin kind = K_ALU; alu_code = ALU_AND; alu_src = 1'b1; end
         6'h0d: begin kind = K_ALU; alu_code = ALU_OR;  alu_src = 1'b1; end
         6'h0f: begin kind = K_ALU; alu_code = ALU_LUI; alu_src = 1'b1; end
         6'h23: begin kind = K_LW;  alu_code = ALU_ADD; alu_src = 1'b1; ext_op = 1'b1; end
         6'h2b: begin kind = K_SW;  alu_code = ALU_ADD; alu_src = 1'b1; ext_op = 1'b1; end
         default: kind = K_NOP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         op_q    <= '0;
         funct_q <= '0;
         bus_err <= 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         illegal <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         bus_err <= bus_err_d;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         illegal <= illegal_d;
`endif
         if (state_q == S_DECODE) begin
            op_q    <= Op;
            funct_q <= Funct;
         end
      end
   end

   // Next state and per-phase datapath controls.
   always_comb begin
      state_d    = state_q;
      bus_err_d  = bus_err;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_d  = illegal;
`endif
      retire     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      NPCOp      = 2'b00;
      RegWrite   = 1'b0;
      ALUSrc     = 1'b0;
      AregSel    = 1'b0;
      EXTOp      = 1'b0;
      ALUOp      = '0;
      GPRSel     = 2'b00;
      WDSel      = 2'b00;
      instr_done = 1'b0;

      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         ALUOp   = ALUOP_W'(alu_code);
         ALUSrc  = alu_src;
         AregSel = areg_sel;
         EXTOp   = ext_op;
      end

      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               state_d = S_DECODE;
            end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (kind == K_NOP) begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
`endif
         end
         S_EXEC: begin
            case (kind)
               K_BEQ:  begin retire = 1'b1; NPCOp = Zero  ? 2'b01 : 2'b00; end
               K_BNE:  begin retire = 1'b1; NPCOp = !Zero ? 2'b01 : 2'b00; end
               K_J:    begin retire = 1'b1; NPCOp = 2'b10; end
               K_JR:   begin retire = 1'b1; NPCOp = 2'b11; end
               K_JAL:  begin
                  retire = 1'b1; NPCOp = 2'b10; RegWrite = 1'b1; WDSel = 2'b10; GPRSel = 2'b10;
               end
               K_JALR: begin
                  retire = 1'b1; NPCOp = 2'b11; RegWrite = 1'b1; WDSel = 2'b10;
               end
               K_LW, K_SW: state_d = S_MEM;
               K_ALU:      state_d = S_WB;
               default:    retire = 1'b1;
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            IorD    = 1'b1;
            mem_we  = (kind == K_SW);
            if (mem_ready) begin
               if (kind == K_SW) retire  = 1'b1;
               else              state_d = S_WB;
            end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            WDSel    = (kind == K_LW) ? 2'b01 : 2'b00;
            GPRSel   = (op_q != 6'h00) ? 2'b01 : 2'b00;
            retire   = 1'b1;
         end
         default: ;
      endcase

      if (retire) begin
         PCWrite    = 1'b1;
         instr_done = 1'b1;
         state_d    = S_FETCH;
      end
      MemWrite = mem_req & mem_we;
   end

   // Count consecutive stalled cycles of one memory access; any state change clears it.
   always_comb begin
      wait_d = '0;
      if (state_d == state_q && (state_q == S_FETCH || state_q == S_MEM))
         wait_d = wait_q + WAIT_W'(1);
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: scoreboard of expected retire records plus reset/timeout checks.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] Op = '0, Funct = '0;
   logic       Zero = 1'b0, mem_ready = 1'b0;
   logic       mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, MemWrite;
   logic       ALUSrc, AregSel, EXTOp, instr_done, bus_err;
   logic [1:0] NPCOp, GPRSel, WDSel;
   logic [3:0] ALUOp;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic       illegal;
`endif

   int n_chk = 0;
   int n_fail = 0;

   typedef struct {
      int         cyc;
      logic [1:0] npc;
      logic       rw;
      logic [1:0] gpr;
      logic [1:0] wd;
      logic [3:0] alu;
      logic       mw;
      logic       src;
      logic       ext;
      logic       areg;
   } exp_t;

   exp_t exp_q[$];

   mc_ctrl dut (
      .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .NPCOp(NPCOp), .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
      .AregSel(AregSel), .EXTOp(EXTOp), .ALUOp(ALUOp), .GPRSel(GPRSel), .WDSel(WDSel),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      .instr_done(instr_done), .bus_err(bus_err), .illegal(illegal)
`else
      .instr_done(instr_done), .bus_err(bus_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({mem_req, mem_we, IorD, IRWrite, PCWrite, NPCOp, RegWrite, MemWrite, ALUSrc,
                  AregSel, EXTOp, ALUOp, GPRSel, WDSel, instr_done, bus_err});
   endfunction

   function automatic exp_t mk(input int cyc, input logic [1:0] npc, input logic rw,
                               input logic [1:0] gpr, input logic [1:0] wd, input logic [3:0] alu,
                               input logic mw, input logic src, input logic ext, input logic areg);
      exp_t e;
      e.cyc = cyc; e.npc = npc; e.rw = rw; e.gpr = gpr; e.wd = wd;
      e.alu = alu; e.mw = mw; e.src = src; e.ext = ext; e.areg = areg;
      return e;
   endfunction

   task automatic step(input logic rdy);
      @(posedge clk); #1 mem_ready = rdy;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_outs", all_outs(), 32'h0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      check("reset_illegal", 32'(illegal), 32'h0);
`endif
      rst = 1'b0;
   endtask

   // Drive one instruction with a responsive memory model; compare at retire against the scoreboard.
   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input int fw, input int mwt, input exp_t e);
      int   cyc = 0, lows = 0, irw_cyc = -1, rw_cnt = 0, need;
      bit   done = 0;
      exp_t x;
      exp_q.push_back(e);
      Op = op; Funct = fn; Zero = z;
      while (!done && cyc < 60) begin
         @(posedge clk); #1;
         if (mem_req) begin
            need = IorD ? mwt : fw;
            mem_ready = (lows >= need);
            lows = mem_ready ? 0 : lows + 1;
         end else begin
            mem_ready = 1'b0;
            lows = 0;
         end
         @(negedge clk);
         cyc++;
         if (IRWrite && irw_cyc < 0) irw_cyc = cyc;
         if (RegWrite) rw_cnt++;
         if (instr_done) begin
            done = 1;
            x = exp_q.pop_front();
            check({tag, "_cycles"}, 32'(cyc), 32'(x.cyc));
            check({tag, "_irwrite_cyc"}, 32'(irw_cyc), 32'(fw + 1));
            check({tag, "_pcwrite"}, 32'(PCWrite), 32'h1);
            check({tag, "_npcop"}, 32'(NPCOp), 32'(x.npc));
            check({tag, "_regwrite"}, 32'(RegWrite), 32'(x.rw));
            check({tag, "_rw_count"}, 32'(rw_cnt), 32'(x.rw));
            check({tag, "_gprsel"}, 32'(GPRSel), 32'(x.gpr));
            check({tag, "_wdsel"}, 32'(WDSel), 32'(x.wd));
            check({tag, "_aluop"}, 32'(ALUOp), 32'(x.alu));
            check({tag, "_memwrite"}, 32'(MemWrite), 32'(x.mw));
            check({tag, "_alusrc"}, 32'(ALUSrc), 32'(x.src));
            check({tag, "_extop"}, 32'(EXTOp), 32'(x.ext));
            check({tag, "_aregsel"}, 32'(AregSel), 32'(x.areg));
         end
      end
      if (!done) check({tag, "_timeout"}, 32'h0, 32'h1);
   endtask

   initial begin
      do_reset();

      //                            op     fn    Z  fw mw       cyc npc rw gpr wd alu mw src ext areg
      run_instr("add",  6'h00, 6'h20, 0, 0, 0, mk(4, 2'd0, 1, 2'd0, 2'd0, 4'd1,  0, 0, 0, 0));
      run_instr("lw",   6'h23, 6'h00, 0, 0, 3, mk(8, 2'd0, 1, 2'd1, 2'd1, 4'd1,  0, 1, 1, 0));
      run_instr("sw",   6'h2b, 6'h00, 0, 2, 0, mk(6, 2'd0, 0, 2'd0, 2'd0, 4'd1,  1, 1, 1, 0));
      run_instr("beqt", 6'h04, 6'h00, 1, 0, 0, mk(3, 2'd1, 0, 2'd0, 2'd0, 4'd2,  0, 0, 1, 0));
      run_instr("beqn", 6'h04, 6'h00, 0, 0, 0, mk(3, 2'd0, 0, 2'd0, 2'd0, 4'd2,  0, 0, 1, 0));
      run_instr("bnet", 6'h05, 6'h00, 0, 0, 0, mk(3, 2'd1, 0, 2'd0, 2'd0, 4'd2,  0, 0, 1, 0));
      run_instr("j",    6'h02, 6'h00, 0, 1, 0, mk(4, 2'd2, 0, 2'd0, 2'd0, 4'd0,  0, 0, 0, 0));
      run_instr("jal",  6'h03, 6'h00, 0, 0, 0, mk(3, 2'd2, 1, 2'd2, 2'd2, 4'd0,  0, 0, 0, 0));
      run_instr("jalr", 6'h00, 6'h09, 0, 0, 0, mk(3, 2'd3, 1, 2'd0, 2'd2, 4'd0,  0, 0, 0, 0));
      run_instr("jr",   6'h00, 6'h08, 0, 0, 0, mk(3, 2'd3, 0, 2'd0, 2'd0, 4'd0,  0, 0, 0, 0));
      run_instr("ori",  6'h0d, 6'h00, 0, 0, 0, mk(4, 2'd0, 1, 2'd1, 2'd0, 4'd4,  0, 1, 0, 0));
      run_instr("addi", 6'h08, 6'h00, 0, 0, 0, mk(4, 2'd0, 1, 2'd1, 2'd0, 4'd1,  0, 1, 1, 0));
      run_instr("lui",  6'h0f, 6'h00, 0, 0, 0, mk(4, 2'd0, 1, 2'd1, 2'd0, 4'd10, 0, 1, 0, 0));
      run_instr("sll",  6'h00, 6'h00, 0, 0, 0, mk(4, 2'd0, 1, 2'd0, 2'd0, 4'd7,  0, 0, 0, 1));
      run_instr("sra",  6'h00, 6'h03, 0, 0, 0, mk(4, 2'd0, 1, 2'd0, 2'd0, 4'd12, 0, 0, 0, 1));
      run_instr("srav", 6'h00, 6'h07, 0, 0, 0, mk(4, 2'd0, 1, 2'd0, 2'd0, 4'd12, 0, 0, 0, 0));
      run_instr("nor",  6'h00, 6'h27, 0, 0, 0, mk(4, 2'd0, 1, 2'd0, 2'd0, 4'd9,  0, 0, 0, 0));
      run_instr("sltu", 6'h00, 6'h2b, 0, 0, 0, mk(4, 2'd0, 1, 2'd0, 2'd0, 4'd6,  0, 0, 0, 0));
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
      run_instr("ill",  6'h3f, 6'h00, 0, 0, 0, mk(3, 2'd0, 0, 2'd0, 2'd0, 4'd0,  0, 0, 0, 0));
`endif

      // Reset asserted in the EXEC cycle of an add clears every output at once.
      Op = 6'h00; Funct = 6'h20;
      step(1'b1);
      step(1'b0);
      @(posedge clk); #1;
      check("exec_aluop_pre_rst", 32'(ALUOp), 32'h1);
      rst = 1'b1;
      #1;
      check("rst_in_exec_outs", all_outs(), 32'h0);
      @(negedge clk);
      check("rst_held_regwrite", 32'(RegWrite), 32'h0);
      rst = 1'b0;
      run_instr("add2", 6'h00, 6'h20, 0, 0, 0, mk(4, 2'd0, 1, 2'd0, 2'd0, 4'd1, 0, 0, 0, 0));

      // Fetch that never completes: 15 stalled cycles tolerated, then HALT with bus_err.
      do_reset();
      for (int i = 1; i <= 16; i++) begin
         step(1'b0);
         if (i == 15) begin
            check("stall15_mem_req", 32'(mem_req), 32'h1);
            check("stall15_bus_err", 32'(bus_err), 32'h0);
         end
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         check("halt_bus_err", 32'(bus_err), 32'h1);
         check("halt_outs", all_outs(), 32'h1);
      end
      do_reset();

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      Op = 6'h3f; Funct = 6'h00;
      step(1'b1);
      check("trap_irwrite", 32'(IRWrite), 32'h1);
      step(1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         check("trap_illegal", 32'(illegal), 32'h1);
         check("trap_halt_outs", all_outs(), 32'h0);
      end
      do_reset();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control unit for the MIPS core. It replaces the single-cycle combinational decoder with a state machine that steps each instruction through fetch, decode, execute, memory and write-back phases. Instruction and data memory are accessed through one shared req/ready handshake with a wait-cycle timeout. It drives the same datapath control signals (RegWrite, MemWrite, ALUOp, NPCOp, GPRSel, WDSel, EXTOp), qualified per phase.

## Interface
- ALUOP_W, 4: ALUOp width; values ≥4 zero-extend the 4-bit codes below.
- WAIT_W, 4: width of the memory wait counter.
- MAX_WAIT, 15: cycles of mem_ready low tolerated per access; must be < 2^WAIT_W.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Op  in  6  opcode from IR; stable from DECODE to end of instruction.
- Funct  in  6  funct from IR.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write qualifier for mem_req.
- IorD  out  1  0 = PC address (fetch), 1 = ALU result (data).
- IRWrite  out  1  load IR.
- PCWrite  out  1  load PC with NPC.
- NPCOp  out  2  00 +4, 01 branch, 10 jump, 11 register.
- RegWrite  out  1  register-file write strobe.
- MemWrite  out  1  same as mem_req & mem_we.
- ALUSrc  out  1  ALU B from immediate.
- AregSel  out  1  ALU A from shamt.
- EXTOp  out  1  sign-extend immediate.
- ALUOp  out  ALUOP_W  ALU operation.
- GPRSel  out  2  00 rd, 01 rt, 10 $31.
- WDSel  out  2  00 ALU, 01 MEM, 10 PC+4.
- instr_done  out  1  one-cycle pulse at instruction retire.
- bus_err  out  1  sticky memory timeout flag.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset: IDLE; every output 0; wait counter 0.
- IDLE -> FETCH unconditionally.
- FETCH: mem_req=1, IorD=0. On mem_ready: IRWrite=1, go DECODE.
- DECODE: latch Op/Funct into internal registers. Illegal encodings -> see Configuration. Otherwise go EXEC.
- EXEC: ALUOp, ALUSrc, AregSel and EXTOp are driven from the latched decode.
  - beq/bne/j/jr: PCWrite=1, NPCOp as below; retire.
  - jal/jalr: also RegWrite=1, WDSel=10; GPRSel=10 for jal, 00 for jalr; retire.
  - lw/sw: go MEM.
  - All others: go WB.
- MEM: mem_req=1, IorD=1, mem_we=sw.
  - sw on mem_ready: retire.
  - lw on mem_ready: go WB.
- WB: RegWrite=1. WDSel=01 for lw, else 00. GPRSel=01 for I-type, 00 for R-type. Retire.
- Retire (same cycle): PCWrite=1, instr_done=1, next state FETCH. NPCOp=00 unless it is a branch/jump.
- NPCOp:
  - 01 on (beq&Zero)|(bne&~Zero), sampled in EXEC.
  - 10 for j/jal.
  - 11 for jr/jalr.
  - A not-taken branch retires with NPCOp=00.
- ALUOp codes:
  - NOP 0, ADD 1 (add/addu/addi/lw/sw), SUB 2 (sub/subu/beq/bne), AND 3 (and/andi), OR 4 (or/ori), SLT 5 (slt/slti), SLTU 6.
  - SLL 7 (sll/sllv), SRL 8 (srl/srlv), NOR 9, LUI 10, XOR 11, SRA 12 (sra/srav).
- AregSel=1 for sll/srl/sra only.
- EXTOp=1 for addi/slti/lw/sw/beq/bne. andi/ori/lui zero-extend.
- Wait counter:
  - Clears on entering FETCH or MEM.
  - Increments each cycle mem_ready=0 while in FETCH or MEM.
  - Reaching MAX_WAIT with mem_ready still 0: bus_err=1, go HALT.
- HALT: all strobes 0, bus_err held; exit only by rst.

## Timing
- Cycle counts with zero wait (mem_ready high in the first request cycle):
  - R-type/ALU-immediate: 4 cycles (FETCH, DECODE, EXEC, WB).
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch/jump/jal/jalr: 3 cycles.
- Each cycle with mem_ready low adds one cycle to FETCH or MEM.
- All strobes (IRWrite, PCWrite, RegWrite, MemWrite) are single-cycle and decoded from the registered state.
- mem_ready is ignored outside FETCH/MEM.
- rst mid-instruction: IDLE immediately. No further PCWrite, RegWrite or MemWrite is issued for the interrupted instruction.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN defined:
  - Adds output `illegal` (1 bit, reset 0).
  - An undecoded Op/Funct in DECODE sets illegal=1 (sticky) and goes HALT; nothing is written.
- Undefined: undecoded encodings execute as NOP (ALUOp=0, no writes) and retire from EXEC with PC+4.

## Test plan
- add $3,$1,$2 (Op=0, Funct=0x20), mem_ready=1:
  - IRWrite in cycle 1.
  - RegWrite, ALUOp=1, GPRSel=00, WDSel=00 in cycle 4.
  - instr_done in cycle 4.
- lw with mem_ready delayed 3 cycles in MEM:
  - MEM lasts 4 cycles; RegWrite with WDSel=01, GPRSel=01 one cycle later.
  - Total 8 cycles.
- beq with Zero=1 -> NPCOp=01 with PCWrite in cycle 3. Zero=0 -> NPCOp=00.
- jal -> cycle 3: RegWrite=1, GPRSel=10, WDSel=10, NPCOp=10, PCWrite=1.
- mem_ready held 0 in FETCH -> bus_err=1 after 15 cycles, HALT, no strobes; rst clears to IDLE.
- Op=0x3F:
  - With MC_CTRL_ILLEGAL_TRAP_EN -> illegal=1, HALT.
  - Without -> retire in 3 cycles, no RegWrite.
  - rst asserted during EXEC -> all outputs 0 in the same cycle.
